// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit counter encodings and history-mode selectors for the branch predictor.
package bp_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b11;
  localparam logic [1:0] ST  = 2'b10;
  localparam int MODE_LOCAL  = 0;
  localparam int MODE_GLOBAL = 1;
  localparam int MODE_GSHARE = 2;
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next state of a 2-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);
  always_comb begin
    next = state;
    case (state)
      SNT: next = taken ? WNT : SNT;
      WNT: next = taken ? WT  : SNT;
      WT:  next = taken ? ST  : WNT;
      ST:  next = taken ? ST  : WT;
    endcase
  end
endmodule

// File: rtl/branch_predict_2lvl.sv
// branch_predict_2lvl: two-level direction predictor (local, global or gshare history)
// with the prediction index carried down the pipeline to train the PHT at commit.
module branch_predict_2lvl
  import bp_pkg::*;
#(
  parameter int MODE      = 0,
  parameter int BHT_DEPTH = 10,
  parameter int PHT_DEPTH = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallD,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushD,
  input  logic             flushE,
  input  logic             flushM,
  input  logic [31:0]      pcF,
  input  logic [31:0]      pcM,
  input  logic             branchD,
  input  logic             branchM,
  input  logic             actual_takeM,
  output logic             pred_takeD,
  output logic             mispredictM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int PN = 1 << PHT_DEPTH;
  logic [1:0]           pht [PN];
  logic [PHT_DEPTH-1:0] idx_f;
  logic [PHT_DEPTH:0]   st_d, st_e, st_m;
  logic [1:0]           pht_next;
  logic                 upd;
  logic                 unused_bits;
  assign upd         = branchM & ~stallM;
  assign pred_takeD  = ~rst & branchD & st_d[PHT_DEPTH];
  assign mispredictM = ~rst & branchM & (st_m[PHT_DEPTH] != actual_takeM);
  assign unused_bits = ^{pcF, pcM};
  bp_sat_counter u_sat (
    .state(pht[st_m[PHT_DEPTH-1:0]]),
    .taken(actual_takeM),
    .next (pht_next)
  );
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < PN; i++) pht[i] <= WT;
    else if (upd) pht[st_m[PHT_DEPTH-1:0]] <= pht_next;
  end
  // Each stage word is {prediction, PHT index}; the index trains the PHT at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_d <= '0;
      st_e <= '0;
      st_m <= '0;
    end else begin
      st_d <= flushD ? '0 : stallD ? st_d : {pht[idx_f][1], idx_f};
      st_e <= flushE ? '0 : stallE ? st_e : st_d;
      st_m <= flushM ? '0 : stallM ? st_m : st_e;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd) begin
      branch_cnt  <= branch_cnt + 1'b1;
      mispred_cnt <= mispred_cnt + CNT_W'(mispredictM);
    end
  end
  generate
    if (MODE == MODE_LOCAL) begin : g_local
      logic [PHT_DEPTH-1:0] bht [1 << BHT_DEPTH];
      always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < (1 << BHT_DEPTH); i++) bht[i] <= '0;
        else if (upd) bht[pcM[BHT_DEPTH+1:2]] <= {bht[pcM[BHT_DEPTH+1:2]][PHT_DEPTH-2:0], actual_takeM};
      end
      assign idx_f = bht[pcF[BHT_DEPTH+1:2]];
    end else begin : g_global
      logic [PHT_DEPTH-1:0] ghr;
      always_ff @(posedge clk) begin
        if (rst) ghr <= '0;
        else if (upd) ghr <= {ghr[PHT_DEPTH-2:0], actual_takeM};
      end
      assign idx_f = (MODE == MODE_GSHARE) ? ghr ^ pcF[PHT_DEPTH+1:2] : ghr;
    end
  endgenerate
endmodule

// File: tb/tb_branch_predict_2lvl.sv
// tb_branch_predict_2lvl: local, global and gshare predictors driven in lockstep against a
// strength-based reference model (0..3, taken when >= 2) with directed and random traffic.
module tb_branch_predict_2lvl;
  logic        clk = 1'b0;
  logic        rst, stallD, stallE, stallM, flushD, flushE, flushM;
  logic [31:0] pcF, pcM;
  logic        branchD, branchM, actual_takeM;
  logic        pt [3];
  logic        mp [3];
  logic [31:0] bcnt [3];
  logic [31:0] mcnt [3];
  logic [3:0]  bc1, mc1;
  int          n_cmp = 0, n_bad = 0;
  int          pht [3][64];
  int          bht [1024];
  int          ghr [3];
  int          pd [3], pe [3], pm [3], id [3], ie [3], im [3];
  bit   [31:0] bc [3], mc [3];
  bit   [31:0] mask [3] = '{32'hffff_ffff, 32'h0000_000f, 32'hffff_ffff};

  always #5 clk = ~clk;

  branch_predict_2lvl #(.MODE(0)) d0 (
    .clk(clk), .rst(rst), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .pcF(pcF), .pcM(pcM),
    .branchD(branchD), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(pt[0]), .mispredictM(mp[0]), .branch_cnt(bcnt[0]), .mispred_cnt(mcnt[0]));
  branch_predict_2lvl #(.MODE(1), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .pcF(pcF), .pcM(pcM),
    .branchD(branchD), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(pt[1]), .mispredictM(mp[1]), .branch_cnt(bc1), .mispred_cnt(mc1));
  branch_predict_2lvl #(.MODE(2)) d2 (
    .clk(clk), .rst(rst), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .pcF(pcF), .pcM(pcM),
    .branchD(branchD), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(pt[2]), .mispredictM(mp[2]), .branch_cnt(bcnt[2]), .mispred_cnt(mcnt[2]));
  assign bcnt[1] = {28'b0, bc1};
  assign mcnt[1] = {28'b0, mc1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(int m, bit [31:0] pc);
    if (m == 0) return bht[pc[11:2]];
    if (m == 1) return ghr[1];
    return ghr[2] ^ int'(pc[7:2]);
  endfunction

  // One clock: drive, compare against the model's pre-edge state, then advance the model.
  task automatic step(input bit r, input bit [2:0] st, input bit [2:0] fl, input bit [31:0] pf,
                      input bit [31:0] pmv, input bit bd, input bit bm, input bit at, input bit chk);
    int fi, fp;
    @(negedge clk);
    rst = r; {stallM, stallE, stallD} = st; {flushM, flushE, flushD} = fl;
    pcF = pf; pcM = pmv; branchD = bd; branchM = bm; actual_takeM = at;
    #1;
    if (chk) for (int m = 0; m < 3; m++) begin
      check($sformatf("pred_takeD m%0d", m), 32'(pt[m]), 32'(!r && bd && pd[m] != 0));
      check($sformatf("mispredictM m%0d", m), 32'(mp[m]), 32'(!r && bm && pm[m] != int'(at)));
      check($sformatf("branch_cnt m%0d", m), bcnt[m], bc[m]);
      check($sformatf("mispred_cnt m%0d", m), mcnt[m], mc[m]);
    end
    for (int m = 0; m < 3; m++) begin
      if (r) begin
        for (int i = 0; i < 64; i++) pht[m][i] = 2;
        if (m == 0) for (int i = 0; i < 1024; i++) bht[i] = 0;
        ghr[m] = 0; pd[m] = 0; pe[m] = 0; pm[m] = 0; id[m] = 0; ie[m] = 0; im[m] = 0;
        bc[m] = 0; mc[m] = 0;
      end else begin
        fi = idx_of(m, pf);
        fp = (pht[m][fi] >= 2) ? 1 : 0;
        if (bm && !st[2]) begin
          pht[m][im[m]] = at ? (pht[m][im[m]] == 3 ? 3 : pht[m][im[m]] + 1)
                             : (pht[m][im[m]] == 0 ? 0 : pht[m][im[m]] - 1);
          if (m == 0) bht[pmv[11:2]] = ((bht[pmv[11:2]] << 1) | int'(at)) & 63;
          else ghr[m] = ((ghr[m] << 1) | int'(at)) & 63;
          bc[m] = (bc[m] + 1) & mask[m];
          if (pm[m] != int'(at)) mc[m] = (mc[m] + 1) & mask[m];
        end
        if (fl[2]) begin pm[m] = 0; im[m] = 0; end
        else if (!st[2]) begin pm[m] = pe[m]; im[m] = ie[m]; end
        if (fl[1]) begin pe[m] = 0; ie[m] = 0; end
        else if (!st[1]) begin pe[m] = pd[m]; ie[m] = id[m]; end
        if (fl[0]) begin pd[m] = 0; id[m] = 0; end
        else if (!st[0]) begin pd[m] = fp; id[m] = fi; end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h200, 32'h200, 0, 0, 0, 1);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fresh predictor: WT everywhere, so 0x100 predicts taken one cycle after fetch.
    step(0, 0, 0, 32'h100, 0, 1, 0, 0, 1);
    step(0, 0, 0, 32'h200, 0, 1, 0, 0, 1);
    step(0, 0, 0, 32'h200, 0, 0, 0, 0, 1);
    step(0, 0, 0, 32'h200, 32'h100, 0, 1, 0, 1);
    step(0, 0, 0, 32'h100, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 32'h200, 32'h100, 0, 1, 0, 1);
    @(posedge clk); #1;
    check("d0 branch_cnt after two commits", bcnt[0], 2);
    check("d0 mispred_cnt after two commits", mcnt[0], 1);
    step(0, 0, 0, 32'h100, 0, 1, 0, 0, 1);
    step(0, 0, 0, 32'h200, 0, 1, 0, 0, 1);
    // Hold D across changing fetch PCs, flush E meanwhile.
    step(0, 3'b001, 0, 32'h104, 0, 1, 0, 0, 1);
    step(0, 3'b001, 3'b010, 32'h108, 0, 1, 0, 0, 1);
    step(0, 3'b001, 0, 32'h10c, 0, 1, 0, 0, 1);
    idle(3);
    // Reset beside a commit: counters clear and PHT stays WT.
    step(0, 0, 0, 32'h0c, 32'h0c, 1, 1, 1, 1);
    step(1, 0, 0, 32'h0c, 32'h0c, 1, 1, 1, 1);
    @(posedge clk); #1;
    check("branch_cnt after rst", bcnt[0], 0);
    check("4-bit branch_cnt after rst", bcnt[1], 0);
    step(0, 0, 0, 32'h0c, 0, 1, 0, 0, 1);
    step(0, 0, 0, 32'h0c, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0}, {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0}, 32'($urandom_range(0, 63)) << 2,
           32'($urandom_range(0, 63)) << 2, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
           $urandom_range(0, 2) != 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
